// File: rtl/sdr_ctrl_pkg.sv
// rtl/sdr_ctrl_pkg.sv - shared types and constants for the UART tuning controller
package sdr_ctrl_pkg;

  localparam int DEF_PHASE_WIDTH    = 64;
  localparam int DEF_GAIN_WIDTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 8_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEX_F,
    ST_HEX_G,
    ST_WAIT_EOL
  } tune_state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_F     = 8'h46;
  localparam logic [7:0] ASCII_G     = 8'h47;
  localparam logic [7:0] CMD_GAIN0   = 8'h30;
  localparam logic [7:0] CMD_GAIN1   = 8'h31;
  localparam logic [7:0] CMD_GAIN2   = 8'h32;
  localparam logic [7:0] CMD_GAIN3   = 8'h33;
  localparam logic [7:0] CMD_PRE_A   = 8'h61;
  localparam logic [7:0] CMD_PRE_B   = 8'h62;
  localparam logic [7:0] CMD_PRE_F   = 8'h66;
  localparam logic [7:0] CMD_PRE_G   = 8'h67;
  localparam logic [7:0] CMD_UP_9K   = 8'h6D;
  localparam logic [7:0] CMD_DN_9K   = 8'h6E;
  localparam logic [7:0] CMD_UP_1K   = 8'h72;
  localparam logic [7:0] CMD_DN_1K   = 8'h71;
  localparam logic [7:0] CMD_UP_100  = 8'h70;
  localparam logic [7:0] CMD_DN_100  = 8'h6F;

  localparam logic [63:0] PRESET_A = 64'h04CF41F212D77318;
  localparam logic [63:0] PRESET_B = 64'h01AA60F8B8911654;
  localparam logic [63:0] PRESET_F = 64'h1DC38C076704516D;
  localparam logic [63:0] PRESET_G = 64'h1D60D923295482C6;

  localparam logic [63:0] STEP_9K  = 64'h00071B375868D170;
  localparam logic [63:0] STEP_1K  = 64'h0000CA22980BA57E;
  localparam logic [63:0] STEP_100 = 64'h00001436A8CDF6F3;

  localparam logic [63:0] DEF_RESET_PHASE_INC = PRESET_B;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_tune_ctrl_if.sv
// rtl/uart_tune_ctrl_if.sv - byte input and tuning output bundle of the controller
interface uart_tune_ctrl_if #(
  parameter int PHASE_WIDTH = 64,
  parameter int GAIN_WIDTH  = 8
);
  logic                   rx_dv;
  logic [7:0]             rx_byte;
  logic [PHASE_WIDTH-1:0] phase_inc;
  logic [GAIN_WIDTH-1:0]  cic_gain;
  logic                   upd;
  logic                   err;
  logic                   busy;

  modport master (
    output rx_dv, rx_byte,
    input  phase_inc, cic_gain, upd, err, busy
  );

  modport slave (
    input  rx_dv, rx_byte,
    output phase_inc, cic_gain, upd, err, busy
  );
endinterface

// File: rtl/hex_nibble_decode.sv
// rtl/hex_nibble_decode.sv - ASCII hex digit to nibble, case-insensitive
module hex_nibble_decode (
  input  logic [7:0] data,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    if (data >= 8'h30 && data <= 8'h39) begin
      nibble = data[3:0];
    end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10
      nibble = data[3:0] + 4'd9;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/uart_tune_ctrl.sv
// rtl/uart_tune_ctrl.sv - UART command decoder driving NCO phase increment and CIC gain
module uart_tune_ctrl
  import sdr_ctrl_pkg::*;
#(
  parameter int                     PHASE_WIDTH     = DEF_PHASE_WIDTH,
  parameter int                     GAIN_WIDTH      = DEF_GAIN_WIDTH,
  parameter int                     TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter logic [PHASE_WIDTH-1:0] RESET_PHASE_INC = PHASE_WIDTH'(DEF_RESET_PHASE_INC)
) (
  input  logic             clk,
  input  logic             arst_n,
  uart_tune_ctrl_if.slave  bus
);

  localparam int F_DIGITS = PHASE_WIDTH / 4;
  localparam int G_DIGITS = GAIN_WIDTH / 4;
  localparam int CNT_W    = $clog2(F_DIGITS + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  tune_state_t            state_q, state_n;
  logic [PHASE_WIDTH-1:0] shift_q, shift_n;
  logic [CNT_W-1:0]       digits_q, digits_n;
  logic [TO_W-1:0]        idle_q, idle_n;
  logic [PHASE_WIDTH-1:0] phase_q, phase_n;
  logic [GAIN_WIDTH-1:0]  gain_q, gain_n;
  logic                   upd_q, upd_n;
  logic                   err_q, err_n;
  logic                   busy_q;

  logic                   nib_valid;
  logic [3:0]             nib;
  logic                   timeout;
  logic [CNT_W-1:0]       digit_target;

  hex_nibble_decode u_hex (
    .data   (bus.rx_byte),
    .valid  (nib_valid),
    .nibble (nib)
  );

  // A byte arriving on the expiry cycle takes priority over the timeout
  assign timeout      = (state_q != ST_IDLE) && !bus.rx_dv &&
                        (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign digit_target = (state_q == ST_HEX_G) ? CNT_W'(G_DIGITS) : CNT_W'(F_DIGITS);

  always_comb begin
    state_n  = state_q;
    shift_n  = shift_q;
    digits_n = digits_q;
    phase_n  = phase_q;
    gain_n   = gain_q;
    upd_n    = 1'b0;
    err_n    = 1'b0;

    if (state_q == ST_IDLE || bus.rx_dv) begin
      idle_n = '0;
    end else begin
      idle_n = idle_q + TO_W'(1);
    end

    if (timeout) begin
      err_n   = 1'b1;
      state_n = ST_IDLE;
      idle_n  = '0;
    end else if (bus.rx_dv) begin
      case (state_q)
        ST_IDLE: begin
          case (bus.rx_byte)
            CMD_GAIN0, CMD_GAIN1, CMD_GAIN2, CMD_GAIN3: begin
              gain_n = GAIN_WIDTH'(bus.rx_byte[1:0]);
              upd_n  = 1'b1;
            end
            CMD_PRE_A:  begin phase_n = PHASE_WIDTH'(PRESET_A);           upd_n = 1'b1; end
            CMD_PRE_B:  begin phase_n = PHASE_WIDTH'(PRESET_B);           upd_n = 1'b1; end
            CMD_PRE_F:  begin phase_n = PHASE_WIDTH'(PRESET_F);           upd_n = 1'b1; end
            CMD_PRE_G:  begin phase_n = PHASE_WIDTH'(PRESET_G);           upd_n = 1'b1; end
            CMD_UP_9K:  begin phase_n = phase_q + PHASE_WIDTH'(STEP_9K);  upd_n = 1'b1; end
            CMD_DN_9K:  begin phase_n = phase_q - PHASE_WIDTH'(STEP_9K);  upd_n = 1'b1; end
            CMD_UP_1K:  begin phase_n = phase_q + PHASE_WIDTH'(STEP_1K);  upd_n = 1'b1; end
            CMD_DN_1K:  begin phase_n = phase_q - PHASE_WIDTH'(STEP_1K);  upd_n = 1'b1; end
            CMD_UP_100: begin phase_n = phase_q + PHASE_WIDTH'(STEP_100); upd_n = 1'b1; end
            CMD_DN_100: begin phase_n = phase_q - PHASE_WIDTH'(STEP_100); upd_n = 1'b1; end
            ASCII_F: begin
              state_n  = ST_HEX_F;
              shift_n  = '0;
              digits_n = '0;
            end
            ASCII_G: begin
              state_n  = ST_HEX_G;
              shift_n  = '0;
              digits_n = '0;
            end
            default: ;
          endcase
        end
        ST_HEX_F, ST_HEX_G: begin
          if (nib_valid) begin
            shift_n  = {shift_q[PHASE_WIDTH-5:0], nib};
            digits_n = digits_q + CNT_W'(1);
            if (digits_n == digit_target) begin
              state_n = ST_WAIT_EOL;
            end
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_WAIT_EOL: begin
          state_n = ST_IDLE;
          if (is_eol(bus.rx_byte)) begin
            // The digit count tells which frame is pending: a gain frame stops at G_DIGITS
            if (digits_q == CNT_W'(G_DIGITS)) begin
              gain_n = shift_q[GAIN_WIDTH-1:0];
            end else begin
              phase_n = shift_q;
            end
            upd_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      digits_q <= '0;
      idle_q   <= '0;
      phase_q  <= RESET_PHASE_INC;
      gain_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      shift_q  <= shift_n;
      digits_q <= digits_n;
      idle_q   <= idle_n;
      phase_q  <= phase_n;
      gain_q   <= gain_n;
      upd_q    <= upd_n;
      err_q    <= err_n;
      busy_q   <= (state_n != ST_IDLE);
    end
  end

  assign bus.phase_inc = phase_q;
  assign bus.cic_gain  = gain_q;
  assign bus.upd       = upd_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tune_ctrl.sv
// tb/tb_uart_tune_ctrl.sv - directed self-checking bench for uart_tune_ctrl
module tb_uart_tune_ctrl;

  localparam logic [63:0] RST_PI = 64'h01AA60F8B8911654;
  localparam logic [63:0] PRE_A  = 64'h04CF41F212D77318;
  localparam logic [63:0] PRE_F  = 64'h1DC38C076704516D;
  localparam logic [63:0] PRE_G  = 64'h1D60D923295482C6;
  localparam logic [63:0] S9K    = 64'h00071B375868D170;
  localparam logic [63:0] S1K    = 64'h0000CA22980BA57E;
  localparam logic [63:0] S100   = 64'h00001436A8CDF6F3;
  localparam logic [7:0]  CR     = 8'h0D;
  localparam logic [7:0]  LF     = 8'h0A;

  logic clk;
  logic arst_n;
  int   vectors;
  int   miscompares;
  int   upd_cnt;
  int   err_cnt;
  int   both_cnt;

  uart_tune_ctrl_if #(.PHASE_WIDTH(64), .GAIN_WIDTH(8)) bus ();

  uart_tune_ctrl #(
    .PHASE_WIDTH     (64),
    .GAIN_WIDTH      (8),
    .TIMEOUT_CYCLES  (100),
    .RESET_PHASE_INC (RST_PI)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.upd) upd_cnt++;
    if (bus.err) err_cnt++;
    if (bus.upd && bus.err) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic put(input logic [7:0] b);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    @(negedge clk);
    bus.rx_dv   = 1'b0;
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    arst_n = 1'b0; bus.rx_dv = 1'b0; bus.rx_byte = 8'h00;
    idle(3);
    vectors++; if (bus.phase_inc !== RST_PI) begin miscompares++; $display("FAIL reset_phase got %h want %h", bus.phase_inc, RST_PI); end
    vectors++; if (bus.cic_gain !== 8'h00) begin miscompares++; $display("FAIL reset_gain got %h want 00", bus.cic_gain); end
    vectors++; if ({bus.upd, bus.err, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {bus.upd, bus.err, bus.busy}); end
    arst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_cmds;
    int u0;
    put("m");
    vectors++; if (bus.upd !== 1'b1) begin miscompares++; $display("FAIL m_upd got %b want 1", bus.upd); end
    vectors++; if (bus.phase_inc !== RST_PI + S9K) begin miscompares++; $display("FAIL m_phase got %h want %h", bus.phase_inc, RST_PI + S9K); end
    idle(1);
    vectors++; if (bus.upd !== 1'b0) begin miscompares++; $display("FAIL upd_pulse_width got %b want 0", bus.upd); end
    put("n");
    vectors++; if (bus.phase_inc !== RST_PI) begin miscompares++; $display("FAIL n_phase got %h want %h", bus.phase_inc, RST_PI); end
    put("3");
    vectors++; if (bus.cic_gain !== 8'd3) begin miscompares++; $display("FAIL gain3 got %h want 03", bus.cic_gain); end
    put("a");
    vectors++; if (bus.phase_inc !== PRE_A) begin miscompares++; $display("FAIL preset_a got %h want %h", bus.phase_inc, PRE_A); end
    put("r");
    vectors++; if (bus.phase_inc !== PRE_A + S1K) begin miscompares++; $display("FAIL r_step got %h want %h", bus.phase_inc, PRE_A + S1K); end
    put("q");
    vectors++; if (bus.phase_inc !== PRE_A) begin miscompares++; $display("FAIL q_step got %h want %h", bus.phase_inc, PRE_A); end
    put("f");
    vectors++; if (bus.phase_inc !== PRE_F) begin miscompares++; $display("FAIL preset_f got %h want %h", bus.phase_inc, PRE_F); end
    put("g");
    vectors++; if (bus.phase_inc !== PRE_G) begin miscompares++; $display("FAIL preset_g got %h want %h", bus.phase_inc, PRE_G); end
    put("p");
    vectors++; if (bus.phase_inc !== PRE_G + S100) begin miscompares++; $display("FAIL p_step got %h want %h", bus.phase_inc, PRE_G + S100); end
    put("b");
    vectors++; if (bus.phase_inc !== RST_PI) begin miscompares++; $display("FAIL preset_b got %h want %h", bus.phase_inc, RST_PI); end
    idle(2);
    u0 = upd_cnt;
    put("z");
    idle(2);
    vectors++; if (upd_cnt - u0 !== 0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL unknown_ignored got upd_delta %0d err %b busy %b want 0 0 0", upd_cnt - u0, bus.err, bus.busy); end
  endtask

  task automatic test_back_to_back;
    int u0;
    u0 = upd_cnt;
    put("1");
    vectors++; if (bus.cic_gain !== 8'd1 || bus.upd !== 1'b1) begin miscompares++; $display("FAIL b2b_gain1 got %h upd %b want 01 1", bus.cic_gain, bus.upd); end
    put("m");
    vectors++; if (bus.phase_inc !== RST_PI + S9K) begin miscompares++; $display("FAIL b2b_m got %h want %h", bus.phase_inc, RST_PI + S9K); end
    put("0");
    vectors++; if (bus.cic_gain !== 8'd0) begin miscompares++; $display("FAIL b2b_gain0 got %h want 00", bus.cic_gain); end
    idle(3);
    vectors++; if (upd_cnt - u0 !== 3) begin miscompares++; $display("FAIL b2b_upd_count got %0d want 3", upd_cnt - u0); end
  endtask

  task automatic test_hex_f;
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt;
    put("F");
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL f_busy_rise got %b want 1", bus.busy); end
    put_str("0123456789ABCDEF");
    vectors++; if (bus.busy !== 1'b1 || bus.phase_inc !== RST_PI + S9K) begin miscompares++; $display("FAIL f_precommit got busy %b phase %h want 1 %h", bus.busy, bus.phase_inc, RST_PI + S9K); end
    put(CR);
    vectors++; if (bus.phase_inc !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL f_commit got %h want 0123456789abcdef", bus.phase_inc); end
    vectors++; if (bus.upd !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL f_commit_flags got upd %b busy %b want 1 0", bus.upd, bus.busy); end
    idle(2);
    vectors++; if (upd_cnt - u0 !== 1 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL f_pulse_count got upd %0d err %0d want 1 0", upd_cnt - u0, err_cnt - e0); end
    put_str("Ffedcba9876543210");
    put(LF);
    vectors++; if (bus.phase_inc !== 64'hFEDCBA9876543210) begin miscompares++; $display("FAIL f_lower got %h want fedcba9876543210", bus.phase_inc); end
  endtask

  task automatic test_hex_g;
    put("2");
    put_str("G1x");
    vectors++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL g_bad_digit got err %b busy %b want 1 0", bus.err, bus.busy); end
    vectors++; if (bus.cic_gain !== 8'd2) begin miscompares++; $display("FAIL g_bad_gain got %h want 02", bus.cic_gain); end
    put_str("G2A");
    put(LF);
    vectors++; if (bus.cic_gain !== 8'h2A || bus.upd !== 1'b1) begin miscompares++; $display("FAIL g_commit got %h upd %b want 2a 1", bus.cic_gain, bus.upd); end
    vectors++; if (bus.phase_inc !== 64'hFEDCBA9876543210) begin miscompares++; $display("FAIL g_phase_kept got %h want fedcba9876543210", bus.phase_inc); end
    put_str("F0123456789ABCDEF5");
    vectors++; if (bus.err !== 1'b1 || bus.phase_inc !== 64'hFEDCBA9876543210) begin miscompares++; $display("FAIL eol_bad got err %b phase %h want 1 fedcba9876543210", bus.err, bus.phase_inc); end
    idle(1);
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    put_str("F12");
    idle(99);
    vectors++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL to_early got err %b busy %b want 0 1", bus.err, bus.busy); end
    idle(1);
    vectors++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL to_fire got err %b busy %b want 1 0", bus.err, bus.busy); end
    idle(2);
    vectors++; if (err_cnt - e0 !== 1 || bus.phase_inc !== 64'hFEDCBA9876543210) begin miscompares++; $display("FAIL to_after got errs %0d phase %h want 1 fedcba9876543210", err_cnt - e0, bus.phase_inc); end
    e0 = err_cnt;
    put_str("F12");
    idle(99);
    put("3");
    vectors++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL to_race got err %b busy %b want 0 1", bus.err, bus.busy); end
    put_str("4567890ABCDEF");
    put(CR);
    vectors++; if (bus.phase_inc !== 64'h1234567890ABCDEF || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL to_race_commit got %h errs %0d want 1234567890abcdef 0", bus.phase_inc, err_cnt - e0); end
  endtask

  task automatic test_wrap;
    put_str("F0000000000000000");
    put(CR);
    vectors++; if (bus.phase_inc !== 64'h0) begin miscompares++; $display("FAIL wrap_zero got %h want 0", bus.phase_inc); end
    put("o");
    vectors++; if (bus.phase_inc !== 64'h0 - S100) begin miscompares++; $display("FAIL wrap_sub got %h want %h", bus.phase_inc, 64'h0 - S100); end
    put("p");
    vectors++; if (bus.phase_inc !== 64'h0) begin miscompares++; $display("FAIL wrap_add got %h want 0", bus.phase_inc); end
  endtask

  task automatic test_async_reset;
    int u0, e0;
    put("a");
    put("3");
    put_str("F1234");
    #2 arst_n = 1'b0;
    #1;
    vectors++; if (bus.phase_inc !== RST_PI || bus.cic_gain !== 8'd0) begin miscompares++; $display("FAIL arst_values got %h %h want %h 00", bus.phase_inc, bus.cic_gain, RST_PI); end
    vectors++; if ({bus.upd, bus.err, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL arst_flags got %b want 000", {bus.upd, bus.err, bus.busy}); end
    @(negedge clk);
    arst_n = 1'b1;
    idle(1);
    u0 = upd_cnt; e0 = err_cnt;
    put(CR);
    vectors++; if (bus.upd !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL arst_cr got upd %b err %b busy %b want 0 0 0", bus.upd, bus.err, bus.busy); end
    idle(2);
    vectors++; if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 0 || bus.phase_inc !== RST_PI) begin miscompares++; $display("FAIL arst_after got upd %0d err %0d phase %h want 0 0 %h", upd_cnt - u0, err_cnt - e0, bus.phase_inc, RST_PI); end
  endtask

  task automatic test_exclusive;
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL upd_err_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    upd_cnt = 0; err_cnt = 0; both_cnt = 0;
    test_reset;
    test_single_cmds;
    test_back_to_back;
    test_hex_f;
    test_hex_g;
    test_timeout;
    test_wrap;
    test_async_reset;
    test_exclusive;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
